uart_tx_feeder: RTL and testbench
=================================

// Module: uart_tx_feeder
// PURPOSE
//  Byte FIFO and launch sequencer that sits directly upstream of the UART transmitter.
//  Accepts bytes from core logic over a valid/ready write port and buffers them.
//  Launches each byte as a one-cycle tx_start/tx_data pulse whenever the transmitter reports not busy.
//  Core logic can therefore queue a burst of message bytes without tracking transmitter timing.
// PARAMETERS
//  DEPTH   16  FIFO entries; power of two, >=2; ADDR_W = $clog2(DEPTH) (localparam)
//  DATA_W  8   byte width; must equal transmitter data width
// PORTS
//  clk       in   1         single clock, shared with transmitter
//  rst_n     in   1         synchronous, active-low reset
//  wr_valid  in   1         write request
//  wr_data   in   DATA_W    byte to queue
//  wr_ready  out  1         = !full; write accepted when wr_valid & wr_ready at posedge clk
//  tx_busy   in   1         transmitter busy (high from cycle after accepted start until stop done)
//  tx_start  out  1         registered, one-cycle launch pulse to transmitter
//  tx_data   out  DATA_W    registered byte; stable from tx_start cycle until next launch
//  level     out  ADDR_W+1  current FIFO occupancy, 0..DEPTH
//  empty     out  1         level==0
//  ovf_clr   in   1         clears overflow
//  overflow  out  1         sticky: write attempted while full (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): wr/rd pointers=0, level=0, empty=1, wr_ready=1, tx_start=0,
//   tx_data=0, overflow=0, FSM=S_IDLE. Queued bytes are discarded.
//  FIFO: circular buffer, wr_ptr/rd_ptr ADDR_W bits wrapping DEPTH-1->0; level counter ADDR_W+1 bits.
//   Push when wr_valid&wr_ready; pop only by FSM in S_IDLE. Push+pop same cycle: level unchanged.
//   Full (level==DEPTH): wr_ready=0 even if pop occurs that cycle; write is ignored, data not stored.
//  FSM (4 states):
//   S_IDLE:      if !empty & !tx_busy -> pop head into tx_data, tx_start<=1, -> S_START.
//   S_START:     tx_start=1 this cycle only; tx_start<=0 -> S_WAIT_BUSY.
//   S_WAIT_BUSY: wait for tx_busy=1 (arrives next cycle) -> S_WAIT_IDLE.
//   S_WAIT_IDLE: wait for tx_busy=0 -> S_IDLE.
//  Latency: byte written at edge N into empty FIFO with idle transmitter gives tx_start=1 in cycle N+2.
//  Back-to-back: next launch 2 cycles after tx_busy falls. No two starts ever issued while busy.
//  Reset during transmission: FSM returns to S_IDLE. The transmitter has no reset, so S_IDLE still
//   gates on !tx_busy and the in-flight frame completes undisturbed.
// CONFIGURATION
//  Macro UART_TX_FEEDER_OVF_EN:
//   defined:   overflow sets on wr_valid & !wr_ready. ovf_clr clears it; if both occur in the same
//              cycle, set wins.
//   undefined: overflow tied 0 and ovf_clr ignored; port list unchanged.
// STRUCTURE
//  uart_pkg: UART_DATA_W=8, FSM state localparams (S_IDLE=2'd0, S_START=1, S_WAIT_BUSY=2,
//   S_WAIT_IDLE=3), shared with the receiver-side blocks.
//  Sub-module uart_fifo_mem: DEPTH x DATA_W register array, sync write, async read of rd_ptr.
//   Pointer and level logic plus FSM stay in uart_tx_feeder.
// TESTING (bench instantiates the transmitter in SIMULATION mode: 1 bit/clk, busy 11 cycles)
//  1 Single byte: write 0xA5 into empty FIFO -> tx_start exactly 1 cycle at N+2, tx_data=0xA5,
//    TxD shows start 0, LSB-first 1,0,1,0,0,1,0,1, then two stop 1s.
//  2 Burst: write 0x01..0x04 back-to-back -> four frames in order, one start each, never while
//    tx_busy=1, level peaks at 3 (head already popped).
//  3 Full: hold tx_busy high externally, write 17 bytes with DEPTH=16 -> level=16, wr_ready=0,
//    17th dropped; overflow=1 with UART_TX_FEEDER_OVF_EN, 0 without; ovf_clr -> 0.
//  4 Wrap: 40 bytes 0x00..0x27 with a random write gap -> all received in order, pointers wrap twice.
//  5 Push/pop collision: write while FSM pops with level=1 -> level stays 1, no byte lost or duplicated.
//  6 Mid-frame reset: rst_n=0 for 1 cycle during bit 3 with 2 bytes queued -> level=0, tx_start=0,
//    no new start until tx_busy falls; a new byte written afterward is launched normally.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and launch-FSM state encoding.
// Used by uart_tx_feeder and the receiver-side blocks.
package uart_pkg;

   localparam int UART_DATA_W = 8;

   typedef logic [1:0] uartState_t;

   localparam uartState_t S_IDLE      = 2'd0;
   localparam uartState_t S_START     = 2'd1;
   localparam uartState_t S_WAIT_BUSY = 2'd2;
   localparam uartState_t S_WAIT_IDLE = 2'd3;

endpackage

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: DEPTH x DATA_W register array.
// Synchronous write, asynchronous read of the addressed entry.
module uart_fifo_mem #(
   parameter int DEPTH  = 16,
   parameter int DATA_W = 8
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] wrAddr,
   input  logic [DATA_W-1:0]        wrData,
   input  logic [$clog2(DEPTH)-1:0] rdAddr,
   output logic [DATA_W-1:0]        rdData
);

   logic [DATA_W-1:0] mem [DEPTH];

   // store the incoming byte at the write pointer
   always_ff @(posedge clk) begin
      if (we) mem[wrAddr] <= wrData;
   end

   assign rdData = mem[rdAddr];

endmodule

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO plus launch sequencer ahead of the UART transmitter.
// Optional sticky overflow flag enabled by macro UART_TX_FEEDER_OVF_EN.
module uart_tx_feeder
   import uart_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int DATA_W = UART_DATA_W
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   wr_valid,
   input  logic [DATA_W-1:0]      wr_data,
   output logic                   wr_ready,
   input  logic                   tx_busy,
   output logic                   tx_start,
   output logic [DATA_W-1:0]      tx_data,
   output logic [$clog2(DEPTH):0] level,
   output logic                   empty,
   input  logic                   ovf_clr,
   output logic                   overflow
);

   localparam int ADDR_W = $clog2(DEPTH);
   localparam logic [ADDR_W:0] LVL_FULL = (ADDR_W + 1)'(DEPTH);

   uartState_t        state;
   uartState_t        nextState;
   logic [ADDR_W-1:0] wrPtr;
   logic [ADDR_W-1:0] rdPtr;
   logic [ADDR_W:0]   levelQ;
   logic [DATA_W-1:0] headData;
   logic [DATA_W-1:0] txDataQ;
   logic              txStartQ;
   logic              full;
   logic              push;
   logic              pop;

   assign full     = (levelQ == LVL_FULL);
   assign wr_ready = !full;
   assign empty    = (levelQ == '0);
   assign level    = levelQ;
   assign tx_start = txStartQ;
   assign tx_data  = txDataQ;

   uart_fifo_mem #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) uMem (
      .clk    (clk),
      .we     (push),
      .wrAddr (wrPtr),
      .wrData (wr_data),
      .rdAddr (rdPtr),
      .rdData (headData)
   );

   // launch-FSM state register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= nextState;
   end

   // launch-FSM next state; S_IDLE keeps gating on tx_busy after reset
   always_comb begin
      nextState = state;
      unique case (state)
         S_IDLE:      if (pop)      nextState = S_START;
         S_START:                   nextState = S_WAIT_BUSY;
         S_WAIT_BUSY: if (tx_busy)  nextState = S_WAIT_IDLE;
         S_WAIT_IDLE: if (!tx_busy) nextState = S_IDLE;
      endcase
   end

   // FSM outputs: FIFO push/pop strobes
   always_comb begin
      push = wr_valid && !full;
      pop  = (state == S_IDLE) && !empty && !tx_busy;
   end

   // pointers and occupancy; push+pop together leaves level unchanged
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wrPtr  <= '0;
         rdPtr  <= '0;
         levelQ <= '0;
      end else begin
         if (push) wrPtr <= wrPtr + 1'b1;
         if (pop)  rdPtr <= rdPtr + 1'b1;
         if (push && !pop)      levelQ <= levelQ + 1'b1;
         else if (pop && !push) levelQ <= levelQ - 1'b1;
      end
   end

   // registered launch pulse and held byte
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         txStartQ <= 1'b0;
         txDataQ  <= '0;
      end else begin
         txStartQ <= pop;
         if (pop) txDataQ <= headData;
      end
   end

`ifdef UART_TX_FEEDER_OVF_EN
   logic ovfQ;

   assign overflow = ovfQ;

   // sticky overflow; a new overflow beats a same-cycle clear
   always_ff @(posedge clk) begin
      if (!rst_n)                    ovfQ <= 1'b0;
      else if (wr_valid && !wr_ready) ovfQ <= 1'b1;
      else if (ovf_clr)              ovfQ <= 1'b0;
   end
`else
   logic unusedOvfClr;

   assign unusedOvfClr = ovf_clr;
   assign overflow     = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: random-stimulus bench with a behavioural 1-bit/clk
// transmitter and an in-order byte scoreboard.
module tb_uart_tx_feeder;

   localparam int DEPTH = 16;
`ifdef UART_TX_FEEDER_OVF_EN
   localparam bit OVF_ON = 1'b1;
`else
   localparam bit OVF_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       wr_valid = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       ovf_clr = 1'b0;
   logic       wr_ready;
   logic       tx_busy;
   logic       tx_start;
   logic [7:0] tx_data;
   logic [4:0] level;
   logic       empty;
   logic       overflow;

   int checks = 0;
   int errors = 0;

   uart_tx_feeder #(
      .DEPTH  (DEPTH),
      .DATA_W (8)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_valid (wr_valid),
      .wr_data  (wr_data),
      .wr_ready (wr_ready),
      .tx_busy  (tx_busy),
      .tx_start (tx_start),
      .tx_data  (tx_data),
      .level    (level),
      .empty    (empty),
      .ovf_clr  (ovf_clr),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // behavioural transmitter: no reset, 11 busy cycles, 1 bit per clock
   int          txCnt = 0;
   logic [10:0] txSh = '1;
   logic        holdBusy = 1'b0;
   logic        txd;

   assign tx_busy = (txCnt != 0) || holdBusy;
   assign txd     = (txCnt != 0) ? txSh[0] : 1'b1;

   always @(posedge clk) begin
      if (txCnt == 0) begin
         if (tx_start && !holdBusy) begin
            txSh  <= {2'b11, tx_data, 1'b0};
            txCnt <= 11;
         end
      end else begin
         txSh  <= {1'b1, txSh[10:1]};
         txCnt <= txCnt - 1;
      end
   end

   // line receiver and protocol monitor
   logic [7:0]  rxQ[$];
   logic [7:0]  expQ[$];
   logic [10:0] rxBits = '1;
   logic [10:0] lastFrame = '0;
   logic        prevStart = 1'b0;
   int          maxLevel = 0;

   always @(negedge clk) begin
      if (txCnt != 0) begin
         rxBits[11 - txCnt] = txd;
         if (txCnt == 1) begin
            lastFrame = rxBits;
            check("frameStart", rxBits[0], 0);
            check("frameStop", rxBits[10:9], 2'b11);
            rxQ.push_back(rxBits[8:1]);
         end
      end
      if (tx_start) begin
         check("startWhileBusy", tx_busy, 0);
         check("startPulseLen", prevStart, 0);
      end
      prevStart = tx_start;
      if (int'(level) > maxLevel) maxLevel = int'(level);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic writeByte(input logic [7:0] b, output bit acc);
      wr_valid = 1'b1;
      wr_data  = b;
      acc      = wr_ready;
      if (acc) expQ.push_back(b);
      tick();
      wr_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (!(empty && txCnt == 0 && rxQ.size() >= expQ.size())
             && n < 3000) begin
         tick();
         n++;
      end
      repeat (3) tick();
      check("drainTimeout", n >= 3000, 0);
      check("rxCount", rxQ.size(), expQ.size());
      for (int i = 0; i < expQ.size() && i < rxQ.size(); i++)
         check($sformatf("rxByte%0d", i), rxQ[i], expQ[i]);
      rxQ.delete();
      expQ.delete();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          a;
      int          acc;
      int          k;
      logic [7:0]  b;
      logic [10:0] f1;

      // reset state
      repeat (3) tick();
      check("rstLevel", level, 0);
      check("rstEmpty", empty, 1);
      check("rstReady", wr_ready, 1);
      check("rstStart", tx_start, 0);
      check("rstData", tx_data, 0);
      check("rstOvf", overflow, 0);
      rst_n = 1'b1;
      tick();

      // single byte: latency, pulse width, frame contents
      wr_valid = 1'b1;
      wr_data  = 8'hA5;
      expQ.push_back(8'hA5);
      tick();
      wr_valid = 1'b0;
      check("latStart0", tx_start, 0);
      check("latLevel1", level, 1);
      tick();
      check("latStart1", tx_start, 1);
      check("latData", tx_data, 8'hA5);
      check("latLevel0", level, 0);
      tick();
      check("latStart2", tx_start, 0);
      check("latHold", tx_data, 8'hA5);
      drain();
      f1 = {2'b11, 8'hA5, 1'b0};
      check("frameA5", lastFrame, f1);

      // burst of four
      maxLevel = 0;
      for (int i = 1; i <= 4; i++) writeByte(8'(i), a);
      drain();
      check("burstPeak", maxLevel, 3);

      // full FIFO with transmitter held busy
      holdBusy = 1'b1;
      acc = 0;
      for (int i = 0; i < DEPTH + 1; i++) begin
         writeByte(8'(8'h80 + i), a);
         acc += int'(a);
      end
      check("fullAccepted", acc, DEPTH);
      check("fullLevel", level, DEPTH);
      check("fullReady", wr_ready, 0);
      check("fullOvf", overflow, OVF_ON);
      wr_valid = 1'b1;
      ovf_clr  = 1'b1;
      tick();
      wr_valid = 1'b0;
      check("ovfSetWins", overflow, OVF_ON);
      tick();
      ovf_clr = 1'b0;
      check("ovfClr", overflow, 0);
      holdBusy = 1'b0;
      drain();

      // wrap: 40 bytes with random gaps
      for (int i = 0; i < 40; i++) begin
         writeByte(8'(i), a);
         repeat ($urandom_range(0, 3)) tick();
      end
      drain();

      // push/pop collision at level 1
      b = 8'($urandom);
      writeByte(b, a);
      check("colLevelA", level, 1);
      writeByte(~b, a);
      check("colLevelB", level, 1);
      drain();

      // reset mid-frame with two bytes queued
      writeByte(8'($urandom), a);
      writeByte(8'($urandom), a);
      writeByte(8'($urandom), a);
      k = 0;
      while (txCnt != 8 && k < 100) begin
         tick();
         k++;
      end
      check("bit3Wait", k >= 100, 0);
      check("preRstLevel", level, 2);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("midRstLevel", level, 0);
      check("midRstEmpty", empty, 1);
      check("midRstStart", tx_start, 0);
      check("midRstBusy", tx_busy, 1);
      void'(expQ.pop_back());
      void'(expQ.pop_back());
      writeByte(8'($urandom), a);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
